modn_counter: RTL and testbench
===============================

MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the modulus (count range 0..N-1).
REQ-002 The module SHALL have the port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have the port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have the port en_i, input, 1 bit: count enable (increment request).
REQ-005 The module SHALL have the port clr_i, input, 1 bit: synchronous clear.
REQ-006 The module SHALL have the port count_o, output, $clog2(N) bits: current count value.
REQ-007 The module SHALL have the port tc_o, output, 1 bit: terminal count flag.

Function
REQ-008 The count register SHALL hold values 0..N-1 only, and count_o SHALL drive it directly (registered output, no combinational path from en_i/clr_i).
REQ-009 On a rising clk_i edge with clr_i=1, count SHALL become 0 regardless of en_i (clear has priority over enable).
REQ-010 On a rising edge with clr_i=0, en_i=1 and count<N-1, count SHALL become count+1.
REQ-011 On a rising edge with clr_i=0, en_i=1 and count==N-1, count SHALL wrap to 0.
REQ-012 On a rising edge with clr_i=0 and en_i=0, count SHALL hold.
REQ-013 tc_o SHALL be combinational, 1 exactly when count==N-1, independent of en_i and clr_i.
REQ-014 The increment SHALL be evaluated in $clog2(N) bits, and the wrap SHALL be an explicit compare to N-1, so that non-power-of-two N never reaches values >=N.
REQ-015 For N a power of two, the natural binary overflow and the explicit wrap SHALL give identical results.
REQ-016 N SHALL be >=2; an elaboration-time check SHALL reject N<2.
REQ-017 A bench SHALL never observe count_o >= N; a non-synthesis assertion SHALL flag it.
REQ-018 Latency SHALL be one cycle: the effect of en_i/clr_i is visible on count_o/tc_o after the next rising edge.

Reset
REQ-019 While rst_n_i=0, count SHALL be 0 immediately (asynchronous), so count_o=0.
REQ-020 While rst_n_i=0, tc_o SHALL be 0, since N>=2.
REQ-021 Deassertion of rst_n_i SHALL take effect without waiting for a clock edge.
REQ-022 Counting SHALL resume on the first rising edge with rst_n_i=1.
REQ-023 Reset asserted mid-count (any value, en_i=1) SHALL force 0 immediately.
REQ-024 The prior count SHALL be lost after reset; no other state exists.

Structure
REQ-025 No shared package SHALL be required: width is derived locally as $clog2(N), and N is the only configuration item.
REQ-026 The block SHALL be a single leaf module with no sub-modules.
REQ-027 The block SHALL consist of one sequential process for the count register and one combinational assignment for tc_o.
REQ-028 The assertions (REQ-016, REQ-017, and tc_o consistency with count) SHALL be placed under a non-synthesis guard.
REQ-029 The module SHALL be reusable as the head/tail pointer counter of circular buffers.

Verification
REQ-030 Reset with N=4: rst_n_i=0 for 2 cycles, then release -> count_o=0, tc_o=0, and count_o=0 immediately on assertion, even between clock edges.
REQ-031 Full sweep with N=4: en_i=1 for 5 edges -> count_o sequence 1,2,3,0,1; tc_o=1 only while count_o=3.
REQ-032 Clear priority with N=4: count_o=2, drive en_i=1 and clr_i=1 for one edge -> count_o=0; with en_i=0 and clr_i=0 -> count_o holds 0.
REQ-033 Non-power-of-two with N=5 (3-bit count): en_i=1 for 6 edges -> 1,2,3,4,0,1; count_o never 5..7; tc_o=1 at count 4.
REQ-034 Hold and reset mid-operation with N=4: count_o=3 with en_i=0 for 3 edges -> stays 3 with tc_o=1; then pulse rst_n_i low asynchronously -> count_o=0 and tc_o=0 before the next edge.

Source files
------------

// File: rtl/modn_counter.sv
// -----------------------------------------------------------------------------
// modn_counter
//
// Modulo-N up counter. The count steps 0, 1, ..., N-1, 0, ... on enabled
// clock edges. It is usable as the head/tail pointer of a circular buffer
// of depth N.
//
// Parameters
//   N        modulus, N >= 2; the count range is 0..N-1
//
// Ports
//   clk_i    clock; all state changes happen on its rising edge
//   rst_n_i  asynchronous active-low reset; forces the count to 0 at once
//   en_i     increment request
//   clr_i    synchronous clear; takes priority over en_i
//   count_o  current count, driven straight from the register
//   tc_o     terminal count, high exactly while count_o == N-1
// -----------------------------------------------------------------------------
module modn_counter #(
    parameter int N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [$clog2(N)-1:0] count_o,
    output logic                 tc_o
);

    localparam int            W    = $clog2(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    // The wrap is an explicit compare against N-1 rather than relying on
    // binary overflow, so non-power-of-two moduli never reach N..2**W-1.
    // For a power-of-two N the two behaviours coincide.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (en_i) begin
            if (count_o == LAST) begin
                count_o <= '0;
            end else begin
                count_o <= count_o + W'(1);
            end
        end
    end

    assign tc_o = (count_o == LAST);

`ifndef SYNTHESIS
    if (N < 2) begin : g_bad_modulus
        $error("modn_counter: N must be >= 2 (got %0d)", N);
    end

    a_count_in_range : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) (32'(count_o) < N)
    ) else $error("modn_counter: count_o=%0d out of range for N=%0d", count_o, N);

    a_tc_consistent : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) (tc_o == (32'(count_o) == N - 1))
    ) else $error("modn_counter: tc_o=%0b inconsistent with count_o=%0d", tc_o, count_o);
`endif

endmodule

// File: tb/tb_modn_counter.sv
module tb_modn_counter;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       en4, clr4, en5, clr5;
    logic [1:0] count4;
    logic [2:0] count5;
    logic       tc4, tc5;

    int n_checks = 0;
    int n_passed = 0;

    always #5 clk_i = ~clk_i;

    modn_counter #(.N(4)) u_dut4 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en4),
        .clr_i   (clr4),
        .count_o (count4),
        .tc_o    (tc4)
    );

    modn_counter #(.N(5)) u_dut5 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en5),
        .clr_i   (clr5),
        .count_o (count5),
        .tc_o    (tc5)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // expected count sequences for the sweeps
    int seq4 [5] = '{1, 2, 3, 0, 1};
    int seq5 [6] = '{1, 2, 3, 4, 0, 1};

    initial begin
        rst_n_i = 1'b0;
        en4 = 1'b0; clr4 = 1'b0;
        en5 = 1'b0; clr5 = 1'b0;

        // reset held for two cycles
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_count4", int'(count4), 0);
        check("rst_tc4",    int'(tc4),    0);
        check("rst_count5", int'(count5), 0);
        check("rst_tc5",    int'(tc5),    0);
        rst_n_i = 1'b1;
        #1;
        check("rel_count4", int'(count4), 0);
        check("rel_tc4",    int'(tc4),    0);

        // N=4 sweep: 1,2,3,0,1
        @(negedge clk_i);
        en4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check($sformatf("sweep4_count[%0d]", i), int'(count4), seq4[i]);
            check($sformatf("sweep4_tc[%0d]", i), int'(tc4), (seq4[i] == 3) ? 1 : 0);
        end

        // one more edge -> 2, then clear with enable high
        @(negedge clk_i);
        check("pre_clr_count4", int'(count4), 2);
        clr4 = 1'b1;
        @(negedge clk_i);
        check("clr_prio_count4", int'(count4), 0);
        en4 = 1'b0; clr4 = 1'b0;
        @(negedge clk_i);
        check("post_clr_hold4", int'(count4), 0);

        // climb to 3 and hold for three edges
        en4 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_i);
            check($sformatf("climb4[%0d]", i), int'(count4), i);
        end
        en4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("hold4_count[%0d]", i), int'(count4), 3);
            check($sformatf("hold4_tc[%0d]", i), int'(tc4), 1);
        end

        // asynchronous reset between edges
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst_count4", int'(count4), 0);
        check("async_rst_tc4",    int'(tc4),    0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check("async_rel_count4", int'(count4), 0);
        en4 = 1'b1;
        @(negedge clk_i);
        check("resume_count4", int'(count4), 1);
        @(negedge clk_i);
        check("resume2_count4", int'(count4), 2);

        // reset mid-count with enable still high
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_midcount_count4", int'(count4), 0);
        check("rst_midcount_count5", int'(count5), 0);
        @(negedge clk_i);
        check("rst_midcount_held4", int'(count4), 0);
        rst_n_i = 1'b1;
        en4 = 1'b0;

        // N=5 sweep: 1,2,3,4,0,1
        en5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check($sformatf("sweep5_count[%0d]", i), int'(count5), seq5[i]);
            check($sformatf("sweep5_range[%0d]", i), int'(count5 < 3'd5), 1);
            check($sformatf("sweep5_tc[%0d]", i), int'(tc5), (seq5[i] == 4) ? 1 : 0);
        end

        // clear on N=5 while enabled
        clr5 = 1'b1;
        @(negedge clk_i);
        check("clr_count5", int'(count5), 0);
        clr5 = 1'b0; en5 = 1'b0;
        @(negedge clk_i);
        check("idle_count4", int'(count4), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
